// File: rtl/pll_clk_gen_pkg.sv
// Shared constants and helpers for the pll_clk_gen clock generator.
package pll_clk_gen_pkg;

    localparam int DEF_CLKOP_DIV   = 4;
    localparam int DEF_CLKOS_DIV   = 8;
    localparam int DEF_CLKOS_PHASE = 2;
    localparam int DEF_LOCK_CNT    = 16;

    // High time of a divided clock; odd dividers get the extra cycle high.
    function automatic int hi_cnt(input int div);
        return (div + 1) / 2;
    endfunction

    // Index a divider starts from so its first rise lags by 'phase' cycles.
    function automatic int start_idx(input int div, input int phase);
        return (div - phase) % div;
    endfunction

endpackage

// File: rtl/clk_div_phase.sv
// Divide-by-DIV square wave with a programmable start index, gated by en.
module clk_div_phase
    import pll_clk_gen_pkg::*;
#(
    parameter int DIV       = DEF_CLKOP_DIV,
    parameter int START_IDX = 0
) (
    input  logic CLKI,
    input  logic RST,
    input  logic en,
    output logic clk_out
);

    localparam int W  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int HI = hi_cnt(DIV);

    logic [W-1:0] idx;
    logic [W-1:0] idx_nxt;
    logic         run;

    always_comb begin
        idx_nxt = (idx == W'(DIV - 1)) ? '0 : idx + W'(1);
    end

    // en is high on the lock edge itself, so the first enabled edge loads the start index.
    always_ff @(posedge CLKI) begin
        if (RST || !en) begin
            idx     <= '0;
            clk_out <= 1'b0;
            run     <= 1'b0;
        end else if (!run) begin
            idx     <= W'(START_IDX);
            clk_out <= (START_IDX < HI);
            run     <= 1'b1;
        end else begin
            idx     <= idx_nxt;
            clk_out <= (idx_nxt < W'(HI));
        end
    end

endmodule

// File: rtl/pll_clk_gen.sv
// PLL-style clock generator: lock counter plus two divided outputs (CLKOP, CLKOS).
// Define CLKOS_PHASE_SHIFT_EN to apply CLKOS_PHASE; otherwise CLKOS is in phase with CLKOP.
module pll_clk_gen
    import pll_clk_gen_pkg::*;
#(
    parameter int CLKOP_DIV   = DEF_CLKOP_DIV,
    parameter int CLKOS_DIV   = DEF_CLKOS_DIV,
    parameter int CLKOS_PHASE = DEF_CLKOS_PHASE,
    parameter int LOCK_CNT    = DEF_LOCK_CNT
) (
    input  logic CLKI,
    input  logic RST,
    output logic CLKOP,
    output logic CLKOS,
    output logic LOCK
);

    localparam int LW = $clog2(LOCK_CNT + 1);

`ifdef CLKOS_PHASE_SHIFT_EN
    localparam int OS_START = start_idx(CLKOS_DIV, CLKOS_PHASE);
`else
    localparam int OS_START = start_idx(CLKOS_DIV, 0);
`endif

    if (CLKOP_DIV < 2) begin : g_bad_op_div
        $fatal(1, "pll_clk_gen: CLKOP_DIV must be >= 2");
    end
    if (CLKOS_DIV < 2) begin : g_bad_os_div
        $fatal(1, "pll_clk_gen: CLKOS_DIV must be >= 2");
    end
    if (CLKOS_PHASE < 0 || CLKOS_PHASE >= CLKOS_DIV) begin : g_bad_phase
        $fatal(1, "pll_clk_gen: CLKOS_PHASE must be in 0..CLKOS_DIV-1");
    end
    if (LOCK_CNT < 1) begin : g_bad_lock
        $fatal(1, "pll_clk_gen: LOCK_CNT must be >= 1");
    end

    logic [LW-1:0] lock_cnt;
    logic          lock_nxt;

    // Value LOCK takes on this edge; drives the dividers so they start on the lock edge.
    assign lock_nxt = !RST && (LOCK || (lock_cnt == LW'(LOCK_CNT - 1)));

    always_ff @(posedge CLKI) begin
        if (RST) begin
            lock_cnt <= '0;
            LOCK     <= 1'b0;
        end else begin
            if (lock_cnt != LW'(LOCK_CNT))
                lock_cnt <= lock_cnt + LW'(1);
            LOCK <= lock_nxt;
        end
    end

    clk_div_phase #(
        .DIV       (CLKOP_DIV),
        .START_IDX (start_idx(CLKOP_DIV, 0))
    ) u_op (
        .CLKI    (CLKI),
        .RST     (RST),
        .en      (lock_nxt),
        .clk_out (CLKOP)
    );

    clk_div_phase #(
        .DIV       (CLKOS_DIV),
        .START_IDX (OS_START)
    ) u_os (
        .CLKI    (CLKI),
        .RST     (RST),
        .en      (lock_nxt),
        .clk_out (CLKOS)
    );

endmodule

// File: tb/tb_pll_clk_gen.sv
// Self-checking bench for pll_clk_gen: default and odd-divider instances against a closed-form model.
module tb_pll_clk_gen;

`ifdef CLKOS_PHASE_SHIFT_EN
    localparam int PH_A = 2;
    localparam int PH_B = 1;
`else
    localparam int PH_A = 0;
    localparam int PH_B = 0;
`endif

    logic CLKI = 1'b0;
    logic RST  = 1'b1;
    logic op_a, os_a, lock_a;
    logic op_b, os_b, lock_b;

    int checks = 0;
    int errors = 0;
    int t      = 0;   // edges with RST low since the last reset edge

    always #5 CLKI = ~CLKI;

    pll_clk_gen u_dut_a (
        .CLKI (CLKI), .RST (RST), .CLKOP (op_a), .CLKOS (os_a), .LOCK (lock_a)
    );

    pll_clk_gen #(
        .CLKOP_DIV (5), .CLKOS_DIV (3), .CLKOS_PHASE (1), .LOCK_CNT (16)
    ) u_dut_b (
        .CLKI (CLKI), .RST (RST), .CLKOP (op_b), .CLKOS (os_b), .LOCK (lock_b)
    );

    // Expected {LOCK, CLKOP, CLKOS} after 'tt' unreset edges, from the timing rules directly.
    function automatic logic [2:0] model(int tt, int lc, int pd, int sd, int ph);
        int n;
        if (tt < lc) return 3'b000;
        n = tt - lc;
        return {1'b1, ((n % pd) < (pd + 1) / 2), (((n + sd - ph) % sd) < (sd + 1) / 2)};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h (t=%0d)", tag, obs, exp, t);
        end
    endtask

    task automatic step(input logic r);
        logic [2:0] ea, eb;
        @(negedge CLKI);
        RST = r;
        @(posedge CLKI);
        t = r ? 0 : t + 1;
        #1;
        ea = model(t, 16, 4, 8, PH_A);
        eb = model(t, 16, 5, 3, PH_B);
        chk("a_lock",  lock_a, ea[2]);
        chk("a_clkop", op_a,   ea[1]);
        chk("a_clkos", os_a,   ea[0]);
        chk("b_lock",  lock_b, eb[2]);
        chk("b_clkop", op_b,   eb[1]);
        chk("b_clkos", os_b,   eb[0]);
    endtask

    initial begin
        int n, rises, first_os, len;
        logic prev;

        repeat (3) step(1'b1);

        n = 0;
        while (lock_a !== 1'b1 && n < 40) begin
            step(1'b0);
            n++;
        end
        chk("lock_latency", n, 16);

        first_os = (os_a === 1'b1) ? 0 : -1;
        prev  = op_a;
        rises = 0;
        for (int i = 1; i <= 40; i++) begin
            step(1'b0);
            if (op_a === 1'b1 && prev === 1'b0) rises++;
            prev = op_a;
            if (first_os < 0 && os_a === 1'b1) first_os = i;
        end
        chk("clkop_rises_40", rises, 10);
        chk("clkos_first_rise", first_os, PH_A);

        n = 0;
        while (op_a !== 1'b1 && n < 8) begin
            step(1'b0);
            n++;
        end
        chk("clkop_high_before_rst", op_a, 1'b1);
        step(1'b1);
        chk("midrst_outputs", {lock_a, op_a, os_a, lock_b, op_b, os_b}, 6'b0);

        n = 0;
        while (lock_a !== 1'b1 && n < 40) begin
            step(1'b0);
            n++;
        end
        chk("relock_latency", n, 16);

        repeat (25) begin
            len = int'($urandom_range(0, 50));
            repeat (len) step(($urandom_range(0, 29) == 0) ? 1'b1 : 1'b0);
            repeat ($urandom_range(1, 3)) step(1'b1);
        end
        repeat (30) step(1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pll_clk_gen.md
Name: pll_clk_gen

Overview:
Digital PLL-style clock generator, fully synchronous to the reference clock CLKI.
- After reset it counts a fixed lock interval, then asserts LOCK.
- Once locked it produces two divided square-wave outputs: CLKOP, and CLKOS with a programmable phase lag.
- Sits at design top as the clock/lock source that the system frequency and phase checks measure.

Parameters:
- CLKOP_DIV, default 4: CLKOP period in CLKI cycles; must be >= 2.
- CLKOS_DIV, default 8: CLKOS period in CLKI cycles; must be >= 2.
- CLKOS_PHASE, default 2: CLKOS lag in CLKI cycles, relative to its zero-phase position; must be 0..CLKOS_DIV-1.
- LOCK_CNT, default 16: CLKI rising edges, with RST low, before LOCK asserts; must be >= 1.

Ports:
- CLKI  input  1  reference clock; all logic on its rising edge.
- RST   input  1  synchronous reset, active-high.
- CLKOP output 1  primary divided clock, registered.
- CLKOS output 1  secondary divided, phase-shifted clock, registered.
- LOCK  output 1  lock indicator, registered.

Behaviour:
- Interface: one clock, CLKI. Reset RST is synchronous and active-high.
- Reset: on any CLKI edge with RST=1:
  - lock counter = 0, op_idx = 0, os_idx = 0.
  - LOCK = 0, CLKOP = 0, CLKOS = 0.
  - Applies mid-operation too; all outputs are low on the edge after RST is sampled high.
- Lock counter:
  - Width $clog2(LOCK_CNT+1); increments each edge with RST=0 and saturates at LOCK_CNT.
  - LOCK <= 1 on the LOCK_CNT-th edge after RST is sampled low (counter reaches LOCK_CNT).
  - LOCK stays 1 until the next reset.
- While LOCK=0: CLKOP and CLKOS are held 0 and both indices are held at 0.
- Lock edge (the edge where LOCK goes 0->1):
  - op_idx <= 0, CLKOP <= 1.
  - os_idx <= (CLKOS_DIV - CLKOS_PHASE) mod CLKOS_DIV.
  - CLKOS <= (that start index < HI_S).
- Each later edge:
  - op_idx <= (op_idx+1) mod CLKOP_DIV, and CLKOP <= (new op_idx < HI_P).
  - os_idx <= (os_idx+1) mod CLKOS_DIV, and CLKOS <= (new os_idx < HI_S).
- High times: HI_P = ceil(CLKOP_DIV/2), HI_S = ceil(CLKOS_DIV/2).
  - Odd dividers are high one cycle longer than low.
- Frequencies: CLKOP = f(CLKI)/CLKOP_DIV, CLKOS = f(CLKI)/CLKOS_DIV.
  - The first CLKOS rising edge after lock trails the first CLKOP rising edge by CLKOS_PHASE cycles.
- Index counter widths: $clog2 of the respective divider. Wrap is exact, with no skipped or extra cycles.
- Parameter legality is checked at elaboration and is fatal on violation.

Optional Feature:
- Macro: CLKOS_PHASE_SHIFT_EN.
- Defined: CLKOS lags as specified by CLKOS_PHASE.
- Undefined: CLKOS_PHASE is ignored and treated as 0; CLKOS starts at index 0 and rises on the lock edge, coincident with CLKOP.

Decomposition:
- Package pll_clk_gen_pkg holds:
  - default divider, phase and lock-count constants;
  - function hi_cnt(div) returning ceil(div/2);
  - function start_idx(div, phase).
- One sub-module, clk_div_phase (parameters DIV, START_IDX), instantiated twice: for CLKOP with START_IDX=0, and for CLKOS.
  - Inputs: CLKI, RST, en (=LOCK).
  - Owns its index counter and registered output.
- Top holds the lock counter and the LOCK register.

Test Plan:
1. Reset: RST=1 for 3 cycles -> LOCK=0, CLKOP=0, CLKOS=0 on every edge during reset.
2. Lock timing (defaults): release RST -> LOCK rises exactly 16 edges later; CLKOP and CLKOS stay 0 before that.
3. CLKOP frequency (defaults): after lock, CLKOP sequence is 1,1,0,0 repeating; exactly 10 rising edges in 40 CLKI cycles.
4. CLKOS, with CLKOS_PHASE_SHIFT_EN:
   - CLKOS period 8, high 4.
   - First CLKOS rise 2 cycles after the first CLKOP rise.
   - Without the macro, both rise on the lock edge.
5. Mid-operation reset: assert RST while CLKOP=1 -> all outputs 0 on the next edge; after release, relock takes 16 edges.
6. Odd divider: CLKOP_DIV=5, CLKOS_DIV=3, CLKOS_PHASE=1 ->
   - CLKOP high 3 / low 2;
   - CLKOS pattern 0,1,1 starting at the lock edge (start index 2).
